// File: rtl/prbs_frame_checker_pkg.sv
// Constants, state encoding and the PRBS-7 word-step function shared by the
// frame transmitter and the frame checker.
package prbs_frame_checker_pkg;

    localparam logic [31:0] SYNC_WORD_DEF = 32'hBC3C_5A5A;
    localparam logic [6:0]  PRBS_SEED     = 7'h7F;
    localparam int          PRBS_TAP_A    = 6;
    localparam int          PRBS_TAP_B    = 5;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_REPORT  = 2'd2
    } state_e;

    // Runs the x^7+x^6+1 generator 32 times; returns {next_state, word}.
    // The first generated bit lands in bit 31 (first on the line).
    function automatic logic [38:0] prbs7_step32(input logic [6:0] s);
        logic [6:0]  st;
        logic [31:0] w;
        logic        b;
        st = s;
        w  = 32'd0;
        for (int i = 31; i >= 0; i--) begin
            b    = st[PRBS_TAP_A] ^ st[PRBS_TAP_B];
            w[i] = b;
            st   = {st[5:0], b};
        end
        return {st, w};
    endfunction

endpackage

// File: rtl/prbs_frame_checker_prbs7_gen.sv
// Parallel PRBS-7 generator: o_word is the word expected for the current
// position; i_advance steps 32 bits, i_load restarts from the seed.
module prbs7_gen
    import prbs_frame_checker_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_advance,
    output logic [31:0] o_word
);

    logic [6:0]  r_state;
    logic [38:0] w_step;

    assign w_step = prbs7_step32(r_state);
    assign o_word = w_step[31:0];

    // Generator state: seed on load, 32-bit step on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PRBS_SEED;
        end else if (i_load) begin
            r_state <= PRBS_SEED;
        end else if (i_advance) begin
            r_state <= w_step[38:32];
        end else begin
            r_state <= r_state;
        end
    end

endmodule

// File: rtl/prbs_frame_checker.sv
// Frame-based PRBS-7 checker: hunts for the sync word, counts bit errors over
// a fixed-length payload and reports per-frame and cumulative statistics.
module prbs_frame_checker
    import prbs_frame_checker_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          FRAME_WORDS = 256,
    parameter logic [31:0] SYNC_WORD   = SYNC_WORD_DEF,
    parameter int          LOSS_THR    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              clear_stats,
    output logic              locked,
    output logic              frame_done,
    output logic [15:0]       frame_err_bits,
    output logic              frame_ok,
    output logic              frame_abort,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       bad_frame_cnt
);

    localparam int              RUN_W     = $clog2(LOSS_THR + 1);
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(LOSS_THR - 1);
    localparam logic [15:0]      LAST_WORD = 16'(FRAME_WORDS - 1);

    state_e            r_state;
    logic [15:0]       r_word_cnt;
    logic [15:0]       r_err_cnt;
    logic [RUN_W-1:0]  r_bad_run;

    logic [31:0]       w_exp_word;
    logic [DATA_W-1:0] w_diff;
    logic [5:0]        w_pop;
    logic [16:0]       w_sum_wide;
    logic [15:0]       w_err_sum;
    logic              w_sync_hit;
    logic              w_word_in;
    logic              w_bad;
    logic              w_abort;
    logic              w_last;
    logic              w_frame_inc;
    logic              w_bad_inc;

    prbs7_gen u_prbs7_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_sync_hit),
        .i_advance (w_word_in),
        .o_word    (w_exp_word)
    );

    assign w_sync_hit = (r_state == ST_HUNT) && rx_valid && (rx_data == SYNC_WORD);
    assign w_word_in  = (r_state == ST_PAYLOAD) && rx_valid;
    assign w_diff     = rx_data ^ w_exp_word;

    // Bit-error count of the current word.
    always_comb begin
        w_pop = 6'd0;
        for (int i = 0; i < DATA_W; i++) begin
            w_pop = w_pop + {5'd0, w_diff[i]};
        end
    end

    assign w_sum_wide  = {1'b0, r_err_cnt} + {11'd0, w_pop};
    assign w_err_sum   = w_sum_wide[16] ? 16'hFFFF : w_sum_wide[15:0];
    assign w_bad       = (w_pop > 6'd8);
    // Loss of lock wins over frame completion when both hit on the same word.
    assign w_abort     = w_word_in && w_bad && (r_bad_run == RUN_LAST);
    assign w_last      = w_word_in && (r_word_cnt == LAST_WORD);
    assign w_frame_inc = w_last && !w_abort;
    assign w_bad_inc   = w_abort || (w_frame_inc && (w_err_sum != 16'd0));

    // Frame FSM with its per-frame counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_HUNT;
            r_word_cnt     <= 16'd0;
            r_err_cnt      <= 16'd0;
            r_bad_run      <= RUN_W'(0);
            locked         <= 1'b0;
            frame_done     <= 1'b0;
            frame_abort    <= 1'b0;
            frame_ok       <= 1'b0;
            frame_err_bits <= 16'd0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (w_sync_hit) begin
                        r_state    <= ST_PAYLOAD;
                        locked     <= 1'b1;
                        r_word_cnt <= 16'd0;
                        r_err_cnt  <= 16'd0;
                        r_bad_run  <= RUN_W'(0);
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_valid) begin
                        r_err_cnt  <= w_err_sum;
                        r_word_cnt <= r_word_cnt + 16'd1;
                        r_bad_run  <= w_bad ? (r_bad_run + RUN_W'(1)) : RUN_W'(0);
                        if (w_abort) begin
                            r_state     <= ST_HUNT;
                            locked      <= 1'b0;
                            frame_abort <= 1'b1;
                        end else if (w_last) begin
                            r_state        <= ST_REPORT;
                            locked         <= 1'b0;
                            frame_done     <= 1'b1;
                            frame_err_bits <= w_err_sum;
                            frame_ok       <= (w_err_sum == 16'd0);
                        end
                    end
                end
                ST_REPORT: begin
                    r_state <= ST_HUNT;
                end
                default: begin
                    r_state <= ST_HUNT;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

    // Cumulative saturating statistics; a clear overrides a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt     <= 16'd0;
            bad_frame_cnt <= 16'd0;
        end else if (clear_stats) begin
            frame_cnt     <= 16'd0;
            bad_frame_cnt <= 16'd0;
        end else begin
            if (w_frame_inc && (frame_cnt != 16'hFFFF)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (w_bad_inc && (bad_frame_cnt != 16'hFFFF)) begin
                bad_frame_cnt <= bad_frame_cnt + 16'd1;
            end
        end
    end

endmodule
